// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the programmable serial-pattern detector.
package seq_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam logic [7:0] DEFAULT_PATTERN = 8'b0000_1010;

endpackage

// File: rtl/seq_match_shifter.sv
// History shift register, fill counter and pattern compare for seq_detect_ctrl.
module seq_match_shifter #(
    parameter int unsigned PAT_W = 4
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match_comb
);

    localparam int unsigned FW = $clog2(PAT_W + 1);

    logic [PAT_W-1:0] hist;
    logic [PAT_W-1:0] hist_next;
    logic [FW-1:0]    fill;
    logic [FW-1:0]    fill_next;

    assign hist_next  = {hist[PAT_W-2:0], din};
    assign fill_next  = (fill == FW'(PAT_W)) ? fill : fill + FW'(1);
    assign match_comb = en && (fill_next == FW'(PAT_W)) && (hist_next == pattern);

    always_ff @(posedge i_clock) begin
        if (i_reset || clr) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= hist_next;
            // Without overlap a match consumes the window: PAT_W fresh bits are needed.
            fill <= (match_comb && !overlap) ? '0 : fill_next;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable pattern detector controller: arm/disarm FSM, match counter, LED stretcher.
import seq_ctrl_pkg::*;

module seq_detect_ctrl #(
    parameter int unsigned PAT_W    = 4,
    parameter int unsigned LED_HOLD = 8,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_cfg_we,
    input  logic [PAT_W-1:0] i_cfg_pattern,
    input  logic             i_cfg_overlap,
    input  logic             i_arm,
    input  logic             i_disarm,
    input  logic             i_btn,
    output logic             o_led,
    output logic             o_match,
    output logic [CNT_W-1:0] o_match_cnt,
    output logic             o_cnt_sat,
    output logic [1:0]       o_state
);

    localparam int unsigned TW = $clog2(LED_HOLD + 1);

    state_t           state;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic [TW-1:0]    timer;
    logic             match_comb;
    logic             clr;
    logic             en;
    logic [CNT_W-1:0] cnt_next;

    assign en       = (state != IDLE);
    assign clr      = i_disarm || ((state == IDLE) && i_arm);
    assign cnt_next = (o_match_cnt == '1) ? o_match_cnt : o_match_cnt + CNT_W'(1);
    assign o_state  = state;

    seq_match_shifter #(
        .PAT_W(PAT_W)
    ) u_shifter (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .clr       (clr),
        .en        (en),
        .din       (i_btn),
        .pattern   (pattern),
        .overlap   (overlap),
        .match_comb(match_comb)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= IDLE;
            pattern     <= DEFAULT_PATTERN[PAT_W-1:0];
            overlap     <= 1'b1;
            timer       <= '0;
            o_led       <= 1'b0;
            o_match     <= 1'b0;
            o_match_cnt <= '0;
            o_cnt_sat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    o_match <= 1'b0;
                    o_led   <= 1'b0;
                    if (i_cfg_we) begin
                        pattern <= i_cfg_pattern;
                        overlap <= i_cfg_overlap;
                    end
                    if (i_arm && !i_disarm) begin
                        state       <= ARMED;
                        o_match_cnt <= '0;
                        o_cnt_sat   <= 1'b0;
                    end
                end
                default: begin
                    if (i_disarm) begin
                        // A match seen on the disarm cycle is dropped.
                        state   <= IDLE;
                        o_led   <= 1'b0;
                        o_match <= 1'b0;
                        timer   <= '0;
                    end else if (match_comb) begin
                        state       <= HOLD;
                        o_match     <= 1'b1;
                        o_led       <= 1'b1;
                        timer       <= TW'(LED_HOLD);
                        o_match_cnt <= cnt_next;
                        o_cnt_sat   <= (cnt_next == '1);
                    end else begin
                        o_match <= 1'b0;
                        if (state == HOLD) begin
                            if (timer == TW'(1)) begin
                                state <= ARMED;
                                o_led <= 1'b0;
                                timer <= '0;
                            end else begin
                                timer <= timer - TW'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench: three configurations share stimulus and are checked against a window model.
module tb_seq_detect_ctrl;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_cfg_we = 1'b0;
    logic [3:0] i_cfg_pattern = 4'h0;
    logic       i_cfg_overlap = 1'b0;
    logic       i_arm = 1'b0;
    logic       i_disarm = 1'b0;
    logic       i_btn = 1'b0;

    logic       a_led, a_match, a_sat, b_led, b_match, b_sat, c_led, c_match, c_sat;
    logic [7:0] a_cnt, c_cnt;
    logic [1:0] b_cnt;
    logic [1:0] a_state, b_state, c_state;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.PAT_W(4), .LED_HOLD(8), .CNT_W(8)) dut_a (
        .i_clock(clk), .i_reset(i_reset), .i_cfg_we(i_cfg_we), .i_cfg_pattern(i_cfg_pattern),
        .i_cfg_overlap(i_cfg_overlap), .i_arm(i_arm), .i_disarm(i_disarm), .i_btn(i_btn),
        .o_led(a_led), .o_match(a_match), .o_match_cnt(a_cnt), .o_cnt_sat(a_sat), .o_state(a_state));

    seq_detect_ctrl #(.PAT_W(4), .LED_HOLD(8), .CNT_W(2)) dut_b (
        .i_clock(clk), .i_reset(i_reset), .i_cfg_we(i_cfg_we), .i_cfg_pattern(i_cfg_pattern),
        .i_cfg_overlap(i_cfg_overlap), .i_arm(i_arm), .i_disarm(i_disarm), .i_btn(i_btn),
        .o_led(b_led), .o_match(b_match), .o_match_cnt(b_cnt), .o_cnt_sat(b_sat), .o_state(b_state));

    seq_detect_ctrl #(.PAT_W(4), .LED_HOLD(1), .CNT_W(8)) dut_c (
        .i_clock(clk), .i_reset(i_reset), .i_cfg_we(i_cfg_we), .i_cfg_pattern(i_cfg_pattern),
        .i_cfg_overlap(i_cfg_overlap), .i_arm(i_arm), .i_disarm(i_disarm), .i_btn(i_btn),
        .o_led(c_led), .o_match(c_match), .o_match_cnt(c_cnt), .o_cnt_sat(c_sat), .o_state(c_state));

    logic [32:0] obs;
    assign obs = {a_state, a_led, a_match, a_cnt, a_sat,
                  b_state, b_led, b_match, b_cnt, b_sat,
                  c_state, c_led, c_match, c_cnt, c_sat};

    int checks = 0;
    int errors = 0;

    // Reference model: armed flag, last PAT_W bits seen, matches since arm, cycle of last match.
    int         cycle = 0;
    bit         m_armed = 1'b0;
    logic [3:0] m_pat = 4'b1010;
    bit         m_ovl = 1'b1;
    bit         hist_q[$];
    bit         m_match = 1'b0;
    int         m_cnt = 0;
    int         m_last = -1000;

    function automatic logic [1:0] st(input bit led);
        if (!m_armed) return 2'd0;
        return led ? 2'd2 : 2'd1;
    endfunction

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [32:0] expv();
        bit la, lc;
        logic [7:0] ca;
        logic [1:0] cb;
        la = m_armed && ((cycle - m_last) < 8);
        lc = m_armed && ((cycle - m_last) < 1);
        ca = 8'(min_i(m_cnt, 255));
        cb = 2'(min_i(m_cnt, 3));
        return {st(la), la, m_match, ca, (m_cnt >= 255),
                st(la), la, m_match, cb, (m_cnt >= 3),
                st(lc), lc, m_match, ca, (m_cnt >= 255)};
    endfunction

    task automatic tick(input bit rst, input bit we, input logic [3:0] pat, input bit ovl,
                        input bit arm, input bit dis, input bit btn);
        logic [3:0] w;
        i_reset = rst; i_cfg_we = we; i_cfg_pattern = pat; i_cfg_overlap = ovl;
        i_arm = arm; i_disarm = dis; i_btn = btn;
        @(posedge clk);
        cycle++;
        if (rst) begin
            m_armed = 0; m_pat = 4'b1010; m_ovl = 1; hist_q.delete();
            m_match = 0; m_cnt = 0; m_last = -1000;
        end else if (!m_armed) begin
            m_match = 0;
            if (we) begin m_pat = pat; m_ovl = ovl; end
            if (arm && !dis) begin m_armed = 1; hist_q.delete(); m_cnt = 0; end
        end else if (dis) begin
            m_armed = 0; hist_q.delete(); m_match = 0; m_last = -1000;
        end else begin
            hist_q.push_back(btn);
            if (hist_q.size() > 4) void'(hist_q.pop_front());
            m_match = 0;
            if (hist_q.size() == 4) begin
                w = '0;
                for (int i = 0; i < 4; i++) w = {w[2:0], hist_q[i]};
                if (w == m_pat) begin
                    m_match = 1; m_cnt++; m_last = cycle;
                    if (!m_ovl) hist_q.delete();
                end
            end
        end
        #1;
    endtask

    task automatic bit_in(input bit b);  tick(0, 0, 4'h0, 0, 0, 0, b); endtask
    task automatic do_arm();             tick(0, 0, 4'h0, 0, 1, 0, 0); endtask
    task automatic do_disarm();          tick(0, 0, 4'h0, 0, 0, 1, 0); endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, 4'h0, 0, 0, 0, 1);
            checks++;
            if (obs !== 33'h0) begin
                errors++;
                $display("FAIL reset cycle %0d got %h expected %h", cycle, obs, 33'h0);
            end
        end
    endtask

    task automatic test_overlap();
        logic [5:0] seq = 6'b101010;
        do_arm();
        for (int i = 0; i < 16; i++) begin
            bit_in((i < 6) ? seq[5 - i] : 1'b0);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL overlap cycle %0d got %h expected %h", cycle, obs, expv());
            end
            if (i == 3 || i == 5) begin
                checks++;
                if (a_match !== 1'b1) begin
                    errors++;
                    $display("FAIL overlap_pulse bit %0d got %b expected 1", i + 1, a_match);
                end
            end
            if (i >= 3 && i < 13) begin
                checks++;
                if (a_led !== 1'b1) begin
                    errors++;
                    $display("FAIL overlap_led bit %0d got %b expected 1", i + 1, a_led);
                end
            end
        end
        checks++;
        if (a_cnt !== 8'd2 || a_led !== 1'b0) begin
            errors++;
            $display("FAIL overlap_count got cnt %0d led %b expected cnt 2 led 0", a_cnt, a_led);
        end
    endtask

    task automatic test_non_overlap();
        logic [7:0] seq = 8'b10101010;
        do_disarm();
        tick(0, 1, 4'b1010, 0, 0, 0, 0);
        do_arm();
        for (int i = 0; i < 8; i++) begin
            bit_in(seq[7 - i]);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL non_overlap cycle %0d got %h expected %h", cycle, obs, expv());
            end
        end
        checks++;
        if (a_cnt !== 8'd2) begin
            errors++;
            $display("FAIL non_overlap_count got %0d expected 2", a_cnt);
        end
    endtask

    task automatic test_cfg_lockout();
        logic [7:0] seq = 8'b1100_1010;
        do_disarm();
        tick(0, 1, 4'b1010, 1, 0, 0, 0);
        do_arm();
        tick(0, 1, 4'b1100, 1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            bit_in(seq[7 - i]);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL cfg_lockout cycle %0d got %h expected %h", cycle, obs, expv());
            end
            checks++;
            if (a_match !== (i == 7)) begin
                errors++;
                $display("FAIL cfg_lockout_match bit %0d got %b expected %b", i, a_match, (i == 7));
            end
        end
    endtask

    task automatic test_disarm_priority();
        logic [3:0] seq = 4'b1010;
        do_disarm();
        do_arm();
        for (int i = 0; i < 3; i++) bit_in(seq[3 - i]);
        tick(0, 0, 4'h0, 0, 1, 1, 0);
        checks++;
        if (a_state !== 2'd0 || a_match !== 1'b0 || a_led !== 1'b0 || obs !== expv()) begin
            errors++;
            $display("FAIL disarm_prio got state %0d match %b led %b expected 0 0 0", a_state, a_match, a_led);
        end
        do_arm();
        checks++;
        if (a_cnt !== 8'd0 || a_state !== 2'd1) begin
            errors++;
            $display("FAIL rearm got cnt %0d state %0d expected 0 1", a_cnt, a_state);
        end
        for (int i = 0; i < 4; i++) begin
            bit_in(seq[3 - i]);
            checks++;
            if (obs !== expv() || a_match !== (i == 3)) begin
                errors++;
                $display("FAIL rearm_match cycle %0d got %h expected %h", cycle, obs, expv());
            end
        end
    endtask

    task automatic test_saturation();
        do_disarm();
        do_arm();
        for (int i = 0; i < 13; i++) begin
            bit_in((i % 2) == 0);
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL saturation cycle %0d got %h expected %h", cycle, obs, expv());
            end
        end
        checks++;
        if (b_cnt !== 2'd3 || b_sat !== 1'b1 || a_cnt !== 8'd5) begin
            errors++;
            $display("FAIL saturation_end got b_cnt %0d b_sat %b a_cnt %0d expected 3 1 5", b_cnt, b_sat, a_cnt);
        end
    endtask

    task automatic test_led_hold1_reset();
        logic [3:0] seq = 4'b1010;
        do_disarm();
        do_arm();
        for (int i = 0; i < 4; i++) bit_in(seq[3 - i]);
        checks++;
        if (c_led !== 1'b1 || c_match !== 1'b1) begin
            errors++;
            $display("FAIL hold1_on got led %b match %b expected 1 1", c_led, c_match);
        end
        bit_in(0);
        checks++;
        if (c_led !== 1'b0 || c_state !== 2'd1 || a_led !== 1'b1 || obs !== expv()) begin
            errors++;
            $display("FAIL hold1_off got c_led %b c_state %0d a_led %b expected 0 1 1", c_led, c_state, a_led);
        end
        tick(1, 0, 4'h0, 0, 0, 0, 1);
        checks++;
        if (obs !== 33'h0) begin
            errors++;
            $display("FAIL reset_in_hold got %h expected %h", obs, 33'h0);
        end
    endtask

    task automatic test_random();
        tick(1, 0, 4'h0, 0, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(299) == 0), ($urandom_range(19) == 0), 4'($urandom),
                 1'($urandom), ($urandom_range(9) == 0), ($urandom_range(59) == 0), 1'($urandom));
            checks++;
            if (obs !== expv()) begin
                errors++;
                $display("FAIL random cycle %0d got %h expected %h", cycle, obs, expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_cfg_lockout();
        test_disarm_priority();
        test_saturation();
        test_led_hold1_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
